piso_shift_ctrl: RTL and testbench

//   Sequencer for a parallel-in/serial-out shift register built on nonblocking (<=) flops.

---
 rtl/piso_shift_ctrl_if.sv | 24 ++
 rtl/piso_shift_ctrl.sv | 125 ++++++++++++
 tb/tb_piso_shift_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/piso_shift_ctrl_if.sv
// Producer-side handshake and serial-line bundle for the PISO shift sequencer.
// The producer owns start/din; the sequencer drives status and the serial outputs.
interface piso_shift_ctrl_if #(
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] din;
   logic         ready;
   logic         busy;
   logic         sout;
   logic         sen;
   logic         bit_strobe;
   logic         done;

   modport master (
      output start, din,
      input  ready, busy, sout, sen, bit_strobe, done
   );

   modport slave (
      input  start, din,
      output ready, busy, sout, sen, bit_strobe, done
   );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out sequencer: captures a W-bit word on start and shifts it out
// MSB first, DIV clocks per bit, followed by a one-cycle done pulse.
module piso_shift_ctrl #(
   parameter int W   = 8,
   parameter int DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   piso_shift_ctrl_if.slave    bus
);
   localparam int BW  = $clog2(W);
   localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0]  BIT_LAST = BW'(W - 1);
   localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_r;
   state_t         next_state_s;
   logic [W-1:0]   shreg_r;
   logic [BW-1:0]  bitcnt_r;
   logic [DVW-1:0] divcnt_r;
   logic           div_wrap_s;
   logic           last_bit_s;

   assign div_wrap_s = (divcnt_r == DIV_LAST);
   assign last_bit_s = (bitcnt_r == BIT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; start is only honoured from IDLE
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               next_state_s = SHIFT;
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            if (div_wrap_s && last_bit_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Shift register, bit counter and bit-period divider
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_r  <= '0;
         bitcnt_r <= '0;
         divcnt_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  shreg_r  <= bus.din;
                  bitcnt_r <= '0;
                  divcnt_r <= '0;
               end
            end
            SHIFT: begin
               if (!div_wrap_s) begin
                  divcnt_r <= divcnt_r + DVW'(1);
               end else begin
                  divcnt_r <= '0;
                  // On the final bit the word is left in place; DONE does not look at it.
                  if (!last_bit_s) begin
                     shreg_r  <= {shreg_r[W-2:0], 1'b0};
                     bitcnt_r <= bitcnt_r + BW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode, purely from flops
   always_comb begin
      bus.ready      = 1'b0;
      bus.busy       = 1'b0;
      bus.sen        = 1'b0;
      bus.sout       = 1'b0;
      bus.bit_strobe = 1'b0;
      bus.done       = 1'b0;
      case (state_r)
         IDLE: begin
            bus.ready = 1'b1;
         end
         SHIFT: begin
            bus.busy       = 1'b1;
            bus.sen        = 1'b1;
            bus.sout       = shreg_r[W-1];
            bus.bit_strobe = (divcnt_r == '0);
         end
         DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.ready = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Bench for piso_shift_ctrl: a DIV=4 and a DIV=1 instance compared cycle by cycle
// against a frame-timeline model (cycle index k within the frame decides every output).
module tb_piso_shift_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst_a;
   logic rst_b;

   piso_shift_ctrl_if #(.W(W)) bus_a ();
   piso_shift_ctrl_if #(.W(W)) bus_b ();

   piso_shift_ctrl #(.W(W), .DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
   piso_shift_ctrl #(.W(W), .DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   // Model: a frame is active for W*DIV+1 cycles after acceptance; k is the cycle index.
   bit         a_act = 1'b0;
   int         a_k   = 0;
   logic [7:0] a_w   = 8'h00;
   bit         b_act = 1'b0;
   int         b_k   = 0;
   logic [7:0] b_w   = 8'h00;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string nm, input bit act, input int k, input logic [7:0] w,
                            input int div, input logic rdy, input logic bsy, input logic sn,
                            input logic so, input logic stb, input logic dn);
      logic e_sen;
      logic e_sout;
      e_sen  = act && (k < W * div);
      e_sout = 1'b0;
      if (e_sen) e_sout = w[7 - k / div];
      chk({nm, ".ready"},      rdy, !act);
      chk({nm, ".busy"},       bsy, act);
      chk({nm, ".sen"},        sn,  e_sen);
      chk({nm, ".sout"},       so,  e_sout);
      chk({nm, ".bit_strobe"}, stb, e_sen && (k % div == 0));
      chk({nm, ".done"},       dn,  act && (k == W * div));
   endtask

   task automatic check_all();
      check_dut("A", a_act, a_k, a_w, 4, bus_a.ready, bus_a.busy, bus_a.sen,
                bus_a.sout, bus_a.bit_strobe, bus_a.done);
      check_dut("B", b_act, b_k, b_w, 1, bus_b.ready, bus_b.busy, bus_b.sen,
                bus_b.sout, bus_b.bit_strobe, bus_b.done);
   endtask

   // One clock: advance the model on the rising edge, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_a) a_act = 1'b0;
      else if (a_act) begin
         if (a_k == W * 4) a_act = 1'b0;
         else a_k++;
      end else if (bus_a.start) begin
         a_act = 1'b1; a_k = 0; a_w = bus_a.din;
      end
      if (rst_b) b_act = 1'b0;
      else if (b_act) begin
         if (b_k == W * 1) b_act = 1'b0;
         else b_k++;
      end else if (bus_b.start) begin
         b_act = 1'b1; b_k = 0; b_w = bus_b.din;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic frame_a(input logic [7:0] d);
      bus_a.din = d;
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      steps(34);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.start = 1'b0; bus_a.din = 8'h00;
      bus_b.start = 1'b0; bus_b.din = 8'h00;
      #1;
      check_all();
      steps(2);
      rst_a = 1'b0;
      rst_b = 1'b0;
      steps(2);

      // Basic frame 0xA5, with a start/0xFF pulse during bit 3 that must be ignored
      bus_a.din = 8'hA5;
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      steps(12);
      bus_a.din = 8'hFF;
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      steps(24);

      // Asynchronous reset during bit 5, then a fresh 0x3C frame
      bus_a.din = 8'h96;
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      steps(21);
      rst_a = 1'b1;
      #1;
      a_act = 1'b0;
      check_all();
      step();
      rst_a = 1'b0;
      steps(2);
      frame_a(8'h3C);

      // Extreme data words
      frame_a(8'h00);
      frame_a(8'hFF);

      // DIV=1 streaming with start held high
      bus_b.din = 8'h81;
      bus_b.start = 1'b1;
      steps(36);
      bus_b.start = 1'b0;
      steps(12);

      // Random traffic on both instances, including start pulses while busy
      for (int i = 0; i < 400; i++) begin
         bus_a.start = ($urandom_range(0, 3) == 0);
         bus_a.din   = 8'($urandom);
         bus_b.start = ($urandom_range(0, 2) == 0);
         bus_b.din   = 8'($urandom);
         step();
      end
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      steps(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
